// File: rtl/tm11r.sv
// tm11r: TM11/TU10 magtape controller front end.
// Unibus slave for the six TM11 registers, ARM-side register window,
// vectored interrupt, and hardware rewind/off-line with per-drive timers.
module tm11r #(
  parameter logic [17:0] ADDR     = 18'o772520,
  parameter logic [7:0]  INTVEC   = 8'o224,
  parameter int          NDRIVES  = 8,
  parameter int          TICKDIV  = 10000,
  parameter int          REWTICKS = 20000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,
  output logic        intreq,
  output logic [7:0]  irvec,
  input  logic        intgnt,
  input  logic [7:0]  igvec,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  input  logic        msyn_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  localparam logic [3:0]    ND4     = 4'(NDRIVES);
  localparam logic [7:0]    DMASK   = 8'((1 << NDRIVES) - 1);
  localparam int            TW      = $clog2(REWTICKS + 1);
  localparam int            PW      = $clog2(TICKDIV + 1);
  localparam logic [TW-1:0] REWLOAD = TW'(REWTICKS);
  localparam logic [PW-1:0] PLAST   = PW'(TICKDIV - 1);

  typedef enum logic [1:0] {CMD_IDLE, CMD_ERR, CMD_HW} cmd_t;

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [14:0]   mtc_r;
  logic [8:0]    mts_hi;    // mts[15:7] error/status bits
  logic [1:0]    mts_mid;   // mts[4:3]
  logic [15:0]   mtbrc, mtcma, mtd, mtrd;
  logic          enable, fastio;
  logic [7:0]    sels, bots, wrls, rews, turs;
  logic [7:0]    rwnd;      // drive timer running
  logic [7:0]    offl;      // running motion is an off-line, not a rewind
  logic [TW-1:0] tmr [8];
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [2:0]    mrcnt;
  logic          mrtog;
  logic          lvl_q;
  cmd_t          cmd_st, cmd_nx;

  logic [2:0]  cur_u, go_u, go_fn, ub_reg, arm_u;
  logic        cur_ok, go_ok, arm_u_ok;
  logic [15:0] mts_full, mtc_full, ub_rdata;
  logic        ub_take, whi, wlo, mtc_wr, pclr, go, go_err, go_hw, lvl;

  // Reset asserts asynchronously and releases on a CLOCK edge
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Composite status of the selected unit; absent units read as zero
  assign cur_u    = mtc_r[10:8];
  assign cur_ok   = ({1'b0, cur_u} < ND4);
  assign mts_full = {mts_hi, sels[cur_u] & cur_ok, bots[cur_u] & cur_ok, mts_mid,
                     wrls[cur_u] & cur_ok, rews[cur_u] & cur_ok, turs[cur_u] & cur_ok};
  assign mtc_full = {|mts_hi, mtc_r};

  // Unibus decode; ARM and INIT take the edge, the bus retries next cycle
  assign ub_take  = msyn_in_h & enable & (a_in_h[17:4] == ADDR[17:4]) & ~ssyn_out_h
                    & ~init_in_h & ~armwrite;
  assign ub_reg   = a_in_h[3:1];
  assign whi      = ~c_in_h[0] | a_in_h[0];
  assign wlo      = ~c_in_h[0] | ~a_in_h[0];
  assign mtc_wr   = ub_take & c_in_h[1] & (ub_reg == 3'd1);
  assign pclr     = mtc_wr & whi & d_in_h[12];
  assign go       = mtc_wr & ~pclr & mtc_r[7] & wlo & ~mtc_r[0] & d_in_h[0];
  assign go_u     = whi ? d_in_h[10:8] : mtc_r[10:8];
  assign go_ok    = ({1'b0, go_u} < ND4);
  assign go_fn    = d_in_h[3:1];
  assign go_err   = go & ~go_ok;
  assign go_hw    = go & go_ok & turs[go_u] & ((go_fn == 3'd7) | (go_fn == 3'd0));
  assign arm_u    = armwdata[26:24];
  assign arm_u_ok = ({1'b0, arm_u} < ND4);

  // Unibus read mux
  always_comb begin
    ub_rdata = 16'd0;
    case (ub_reg)
      3'd0: ub_rdata = mts_full;
      3'd1: ub_rdata = mtc_full & 16'o167776;
      3'd2: ub_rdata = mtbrc;
      3'd3: ub_rdata = mtcma & 16'o177776;
      3'd4: ub_rdata = mtd;
      3'd5: ub_rdata = mtrd;
      default: ub_rdata = 16'd0;
    endcase
  end

  // ARM register window
  always_comb begin
    armrdata = 32'hDEADBEEF;
    case (armraddr)
      3'd0: armrdata = 32'h544D2002;
      3'd1: armrdata = {mtc_full, mts_full};
      3'd2: armrdata = {mtcma, mtbrc};
      3'd3: armrdata = {mtrd, mtd};
      3'd4: armrdata = {enable, fastio, 4'b0000, INTVEC, ADDR};
      3'd5: armrdata = {bots, wrls, rews, turs};
      3'd6: armrdata = {20'd0, ND4, sels};
      3'd7: armrdata = {24'd0, rwnd};
      default: armrdata = 32'hDEADBEEF;
    endcase
  end

  // ARM wake-up is held off while a hardware-handled GO is finishing
  assign armintrq = (mtc_r[0] & (cmd_st == CMD_IDLE)) | mtc_r[12];

  // Command finish state register
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) cmd_st <= CMD_IDLE;
    else        cmd_st <= cmd_nx;
  end

  // A GO that the hardware resolves itself completes one clock later
  always_comb begin
    cmd_nx = CMD_IDLE;
    if (go_err)     cmd_nx = CMD_ERR;
    else if (go_hw) cmd_nx = CMD_HW;
  end

  // Shared motion-tick prescaler and MTRD[15] clock divider
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      tick  <= 1'b0;
      mrcnt <= 3'd0;
      mrtog <= 1'b0;
    end else begin
      tick  <= 1'b0;
      mrtog <= 1'b0;
      if (pcnt == PLAST) begin
        pcnt <= '0;
        tick <= 1'b1;
        if (mrcnt == 3'd4) begin
          mrcnt <= 3'd0;
          mrtog <= 1'b1;
        end else begin
          mrcnt <= mrcnt + 3'd1;
        end
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Edge-triggered Unibus interrupt request
  assign lvl   = (mtc_full[15] | mtc_r[7]) & mtc_r[6];
  assign irvec = intreq ? INTVEC : 8'd0;

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      intreq <= 1'b0;
      lvl_q  <= 1'b0;
    end else begin
      lvl_q <= lvl;
      if (init_in_h)                       intreq <= 1'b0;
      else if (lvl && !lvl_q)              intreq <= 1'b1;
      else if (intgnt && igvec == INTVEC)  intreq <= 1'b0;
    end
  end

  // Registers, drive state, timers and the Unibus slave handshake
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      mtc_r      <= '0;
      mts_hi     <= '0;
      mts_mid    <= '0;
      mtbrc      <= '0;
      mtcma      <= '0;
      mtd        <= '0;
      mtrd       <= '0;
      enable     <= 1'b0;
      fastio     <= 1'b0;
      sels       <= '0;
      bots       <= '0;
      wrls       <= '0;
      rews       <= '0;
      turs       <= '0;
      rwnd       <= '0;
      offl       <= '0;
      ssyn_out_h <= 1'b0;
      d_out_h    <= '0;
      for (int i = 0; i < 8; i++) tmr[i] <= '0;
    end else begin
      if (mrtog) mtrd[15] <= ~mtrd[15];

      // Timers keep running across INIT, as a real drive would
      for (int i = 0; i < 8; i++) begin
        if (tick && rwnd[i]) begin
          if (tmr[i] <= TW'(1)) begin
            tmr[i]  <= '0;
            rwnd[i] <= 1'b0;
            rews[i] <= 1'b0;
            bots[i] <= 1'b1;
            if (offl[i]) sels[i] <= 1'b0;
            else         turs[i] <= 1'b1;
          end else begin
            tmr[i] <= tmr[i] - 1'b1;
          end
        end
      end

      case (cmd_st)
        CMD_ERR: begin
          mts_hi[8] <= 1'b1;
          mtc_r[7]  <= 1'b1;
          mtc_r[0]  <= 1'b0;
        end
        CMD_HW: begin
          mtc_r[7] <= 1'b1;
          mtc_r[0] <= 1'b0;
        end
        default: ;
      endcase

      if (ssyn_out_h && !msyn_in_h) begin
        ssyn_out_h <= 1'b0;
        d_out_h    <= '0;
      end

      if (init_in_h) begin
        mtc_r  <= 15'o10000;
        mts_hi <= '0;
      end else if (armwrite) begin
        case (armwaddr)
          3'd1: begin
            mtc_r   <= armwdata[30:16];
            mts_hi  <= armwdata[15:7];
            mts_mid <= armwdata[4:3];
            if (arm_u_ok) begin
              sels[arm_u] <= armwdata[6];
              bots[arm_u] <= armwdata[5];
              wrls[arm_u] <= armwdata[2];
              rews[arm_u] <= armwdata[1];
              turs[arm_u] <= armwdata[0];
            end
          end
          3'd2: begin
            mtcma <= armwdata[31:16];
            mtbrc <= armwdata[15:0];
          end
          3'd3: begin
            mtrd <= armwdata[31:16];
            mtd  <= armwdata[15:0];
          end
          3'd4: begin
            enable <= armwdata[31];
            fastio <= armwdata[30];
          end
          3'd5: begin
            bots <= armwdata[31:24] & DMASK;
            wrls <= armwdata[23:16] & DMASK;
            rews <= armwdata[15:8]  & DMASK;
            turs <= armwdata[7:0]   & DMASK;
            for (int i = 0; i < 8; i++) begin
              if (!armwdata[8 + i]) begin
                rwnd[i] <= 1'b0;
                tmr[i]  <= '0;
              end
            end
          end
          3'd6: sels <= armwdata[7:0] & DMASK;
          default: ;
        endcase
      end else if (ub_take) begin
        ssyn_out_h <= 1'b1;
        if (!c_in_h[1]) begin
          d_out_h <= ub_rdata;
        end else begin
          case (ub_reg)
            3'd1: begin
              if (pclr) begin
                mts_hi      <= '0;
                mtc_r[14:8] <= d_in_h[14:8];
                mtc_r[0]    <= 1'b0;
              end else if (!mtc_r[7]) begin
                mts_hi[8] <= 1'b1;
              end else begin
                if (whi) mtc_r[14:8] <= d_in_h[14:8];
                if (wlo) mtc_r[6:0]  <= d_in_h[6:0];
                if (go) begin
                  mtc_r[7] <= 1'b0;
                  mts_hi   <= '0;
                end
                if (go_hw) begin
                  turs[go_u] <= 1'b0;
                  rews[go_u] <= 1'b1;
                  bots[go_u] <= 1'b0;
                  rwnd[go_u] <= 1'b1;
                  offl[go_u] <= (go_fn == 3'd0);
                  tmr[go_u]  <= REWLOAD;
                end
              end
            end
            3'd2: begin
              if (whi) mtbrc[15:8] <= d_in_h[15:8];
              if (wlo) mtbrc[7:0]  <= d_in_h[7:0];
            end
            3'd3: begin
              if (whi) mtcma[15:8] <= d_in_h[15:8];
              if (wlo) mtcma[7:0]  <= d_in_h[7:0];
            end
            3'd4: begin
              if (whi) mtd[15:8] <= d_in_h[15:8];
              if (wlo) mtd[7:0]  <= d_in_h[7:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
